// File: rtl/score_keeper_pkg.sv
// Shared game definitions for the score path.
// Used by score_keeper, the renderer and game logic.
package score_keeper_pkg;

    // Score FSM states.
    typedef enum logic {
        PLAY = 1'b0,
        WON  = 1'b1
    } state_e;

    localparam int SCORE_W = 4;
    localparam int PIX_W   = 10;

    // Pixel coordinate that marks the start of a frame.
    localparam logic [PIX_W-1:0] FRAME_X0 = '0;
    localparam logic [PIX_W-1:0] FRAME_Y0 = '0;

    localparam int DEF_MAX_SCORE    = 9;
    localparam int DEF_WIN_SCORE    = 9;
    localparam int DEF_BLINK_FRAMES = 30;

    // Increment that holds at the ceiling instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] v,
        input logic [SCORE_W-1:0] ceil
    );
        return (v >= ceil) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/score_keeper_frame_tick.sv
// One-clock pulse on entry to the frame origin.
// Holding at the origin for several clocks gives one pulse.
module frame_tick_gen
    import score_keeper_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pix_x,
    input  logic [PIX_W-1:0] pix_y,
    output logic             frame_tick
);

    logic w_at_origin;
    logic r_origin_q;
    logic r_tick;

    assign w_at_origin = (pix_x == FRAME_X0) && (pix_y == FRAME_Y0);
    assign frame_tick  = r_tick;

    // Register origin flag and emit a pulse on its rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_origin_q <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_origin_q <= w_at_origin;
            r_tick     <= w_at_origin & ~r_origin_q;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Hit counter with frame-synchronised score display,
// win detection and blink-blank generation.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int MAX_SCORE    = DEF_MAX_SCORE,
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PIX_W-1:0]   pix_x,
    input  logic [PIX_W-1:0]   pix_y,
    input  logic               hit,
    input  logic               clear,
    output logic [SCORE_W-1:0] score,
    output logic               win,
    output logic               score_blank
);

    localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

    localparam int BLINK_W =
        (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST =
        BLINK_W'(BLINK_FRAMES - 1);

    logic               w_frame_tick;
    logic               w_hit_rise;

    logic               r_hit_q;
    state_e             r_state;
    logic [SCORE_W-1:0] r_count;
    logic [SCORE_W-1:0] r_score;
    logic               r_win;
    logic               r_blank;
    logic [BLINK_W-1:0] r_blink;

    frame_tick_gen u_frame_tick (
        .clk        (clk),
        .reset      (reset),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .frame_tick (w_frame_tick)
    );

    assign w_hit_rise  = hit & ~r_hit_q;
    assign score       = r_score;
    assign win         = r_win;
    assign score_blank = r_blank;

    // Track hit even during clear so a held level never re-counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_q <= 1'b0;
        end else begin
            r_hit_q <= hit;
        end
    end

    // Score FSM: count, display latch, win and blink.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PLAY;
            r_count <= '0;
            r_score <= '0;
            r_win   <= 1'b0;
            r_blank <= 1'b0;
            r_blink <= '0;
        end else if (clear) begin
            r_state <= PLAY;
            r_count <= '0;
            r_score <= '0;
            r_win   <= 1'b0;
            r_blank <= 1'b0;
            r_blink <= '0;
        end else begin
            if (w_frame_tick) begin
                r_score <= r_count;
            end
            case (r_state)
                PLAY: begin
                    r_blink <= '0;
                    r_blank <= 1'b0;
                    if (w_hit_rise) begin
                        r_count <= sat_inc(r_count, MAX_S);
                    end
                    if (r_count == WIN_S) begin
                        r_state <= WON;
                        r_win   <= 1'b1;
                    end else begin
                        r_win   <= 1'b0;
                    end
                end
                WON: begin
                    r_win <= 1'b1;
                    if (w_frame_tick) begin
                        if (r_blink == BLINK_LAST) begin
                            r_blink <= '0;
                            r_blank <= ~r_blank;
                        end else begin
                            r_blink <= r_blink + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= PLAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper.
// Frames are produced on demand by parking pixels at the origin.
module tb_score_keeper;

    logic       clk;
    logic       reset;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       hit;
    logic       clear;
    logic [3:0] score;
    logic       win;
    logic       score_blank;

    int n_checks;
    int n_fails;
    int tick_cnt;
    int t0;

    score_keeper dut (
        .clk         (clk),
        .reset       (reset),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .hit         (hit),
        .clear       (clear),
        .score       (score),
        .win         (win),
        .score_blank (score_blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame ticks seen by the datapath.
    always @(posedge clk) begin
        if (dut.w_frame_tick) tick_cnt <= tick_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        cyc(1);
    endtask

    task automatic frame(input int hold);
        pix_x = 10'd0;
        pix_y = 10'd0;
        cyc(hold);
        pix_x = 10'd5;
        pix_y = 10'd5;
        cyc(2);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        tick_cnt = 0;
        reset = 1'b1;
        clear = 1'b0;
        hit   = 1'b0;
        pix_x = 10'd5;
        pix_y = 10'd5;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("reset_score", score, 0);
        chk("reset_win", win, 0);
        chk("reset_blank", score_blank, 0);

        // three spaced pulses mid-frame
        repeat (3) begin
            pulse();
            cyc(3);
        end
        chk("midframe_hold", score, 0);
        frame(1);
        chk("three_hits", score, 3);
        chk("three_win", win, 0);
        chk("three_blank", score_blank, 0);

        // long level counts once
        hit = 1'b1;
        cyc(10);
        frame(1);
        chk("level_tick1", score, 4);
        cyc(40);
        frame(1);
        chk("level_tick2", score, 4);
        cyc(40);
        hit = 1'b0;
        cyc(2);

        // hit rise coincides with frame tick
        pix_x = 10'd0;
        pix_y = 10'd0;
        cyc(1);
        pix_x = 10'd5;
        pix_y = 10'd5;
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        chk("coinc_pre", score, 4);
        cyc(2);
        frame(1);
        chk("coinc_post", score, 5);

        // climb to the win score
        repeat (3) pulse();
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        chk("win_before", win, 0);
        cyc(1);
        chk("win_after", win, 1);
        repeat (8) pulse();
        frame(1);
        chk("sat_score", score, 9);
        chk("won_blank_t1", score_blank, 0);

        // blink phases
        repeat (28) frame(1);
        chk("blank_t29", score_blank, 0);
        frame(1);
        chk("blank_t30", score_blank, 1);
        repeat (29) frame(1);
        chk("blank_t59", score_blank, 1);
        frame(1);
        chk("blank_t60", score_blank, 0);
        repeat (29) frame(1);
        chk("blank_t89", score_blank, 0);
        frame(1);
        chk("blank_t90", score_blank, 1);
        chk("won_score", score, 9);
        chk("won_win", win, 1);

        // clear with hit high in WON
        clear = 1'b1;
        hit   = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("clr_score", score, 0);
        chk("clr_win", win, 0);
        chk("clr_blank", score_blank, 0);
        cyc(3);
        frame(1);
        chk("clr_held_hit", score, 0);
        hit = 1'b0;
        cyc(1);
        pulse();
        frame(1);
        chk("clr_rearm", score, 1);

        // origin held for four clocks
        pulse();
        t0 = tick_cnt;
        frame(4);
        chk("hold_ticks", tick_cnt - t0, 1);
        chk("hold_score", score, 2);
        pulse();
        cyc(5);
        chk("hold_no_tick", score, 2);
        frame(1);
        chk("hold_next", score, 3);

        // reset mid-frame
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("rst2_score", score, 0);
        frame(1);
        chk("rst2_frame", score, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
